// File: rtl/icache_l1_if.sv
// Cache request/response and line-fill signal bundle.
// No storage; pure wiring between requester, cache and next level.
// Requester holds mem_read until mem_resp; cache holds pmem_read until pmem_resp.
interface icache_l1_if;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_resp;
    logic [127:0] mem_rdata;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    // cache side
    modport slave (
        input  mem_address, mem_read, pmem_rdata, pmem_resp,
        output mem_resp, mem_rdata, pmem_address, pmem_read
    );

    // environment side (fetch stage plus next memory level)
    modport master (
        output mem_address, mem_read, pmem_rdata, pmem_resp,
        input  mem_resp, mem_rdata, pmem_address, pmem_read
    );
endinterface

// File: rtl/icache_l1.sv
// 2-way x 8-set instruction cache with 128-bit lines and per-set LRU.
// Hit: 0 cycles (combinational); miss: next-level latency + 1 cycle.
// Requester holds mem_read until mem_resp; fill request held until pmem_resp.
module icache_l1 (
    input  logic       clk,
    input  logic       reset,
    icache_l1_if.slave bus
);
    typedef enum logic {IDLE, ALLOCATE} state_t;

    state_t       state, state_nxt;

    logic [1:0][7:0] valid_q;
    logic [8:0]      tag_q  [2][8];
    logic [127:0]    data_q [2][8];
    logic [7:0]      lru_q;          // per set: way to evict next
    logic [11:0]     miss_line_q;    // {tag, index} of the line being fetched

    logic [2:0]   req_idx;
    logic [8:0]   req_tag;
    logic         hit_w0, hit_w1, hit_any;
    logic [2:0]   fill_idx;
    logic [8:0]   fill_tag;
    logic         victim;

    logic         resp;
    logic [127:0] rdata;
    logic         pread;
    logic [15:0]  paddr;
    logic         miss_load;
    logic         hit_upd;
    logic         fill_we;

    assign req_idx  = bus.mem_address[6:4];
    assign req_tag  = bus.mem_address[15:7];
    assign hit_w0   = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
    assign hit_w1   = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
    assign hit_any  = hit_w0 || hit_w1;
    assign fill_idx = miss_line_q[2:0];
    assign fill_tag = miss_line_q[11:3];

    assign bus.mem_resp     = resp;
    assign bus.mem_rdata    = rdata;
    assign bus.pmem_read    = pread;
    assign bus.pmem_address = paddr;

    // victim: fill empty ways first (way 0 before way 1), otherwise follow LRU
    always_comb begin
        victim = 1'b0;
        if (!valid_q[0][fill_idx])
            victim = 1'b0;
        else if (!valid_q[1][fill_idx])
            victim = 1'b1;
        else
            victim = lru_q[fill_idx];
    end

    // next-state and output decode; hits are served only from IDLE
    always_comb begin
        state_nxt = state;
        resp      = 1'b0;
        rdata     = '0;
        pread     = 1'b0;
        paddr     = '0;
        miss_load = 1'b0;
        hit_upd   = 1'b0;
        fill_we   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_read && !reset) begin
                    if (hit_any) begin
                        resp    = 1'b1;
                        rdata   = hit_w1 ? data_q[1][req_idx] : data_q[0][req_idx];
                        hit_upd = 1'b1;
                    end else begin
                        miss_load = 1'b1;
                        state_nxt = ALLOCATE;
                    end
                end
            end
            ALLOCATE: begin
                pread = 1'b1;
                paddr = {miss_line_q, 4'h0};
                if (bus.pmem_resp) begin
                    fill_we   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // valid bits, LRU and the latched miss line
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= '0;
            lru_q       <= '0;
            miss_line_q <= '0;
        end else begin
            if (miss_load)
                miss_line_q <= bus.mem_address[15:4];
            if (hit_upd)
                lru_q[req_idx] <= hit_w0;
            if (fill_we) begin
                valid_q[victim][fill_idx] <= 1'b1;
                lru_q[fill_idx]           <= ~victim;
            end
        end
    end

    // tag/data arrays carry no reset; valid bits qualify their contents
    always_ff @(posedge clk) begin
        if (fill_we && !reset) begin
            tag_q[victim][fill_idx]  <= fill_tag;
            data_q[victim][fill_idx] <= bus.pmem_rdata;
        end
    end
endmodule

// File: tb/tb_icache_l1.sv
// Directed bench for icache_l1: cold miss, hit stream, LRU conflict,
// abandoned request, spurious fill response and reset during a fill.
// Inputs are driven 2 time units after the rising edge, outputs sampled 1 unit later.
module tb_icache_l1;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    icache_l1_if bus ();

    icache_l1 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic logic [127:0] line_of(input logic [15:0] a);
        logic [15:0] b;
        b = {a[15:4], 4'h0};
        return {16'hC0DE, b, ~b, 16'h5A5A, b ^ 16'h0F0F, 16'h1111, b, 16'hFFFF - b};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic rd, input logic [15:0] a);
        bus.mem_read    = rd;
        bus.mem_address = a;
        #1;
    endtask

    task automatic expect_resp(input string tag, input logic r, input logic [127:0] d);
        check({tag, ".resp"}, 128'(bus.mem_resp), 128'(r));
        check({tag, ".rdata"}, bus.mem_rdata, d);
    endtask

    task automatic expect_pmem(input string tag, input logic rd, input logic [15:0] a);
        check({tag, ".pread"}, 128'(bus.pmem_read), 128'(rd));
        check({tag, ".paddr"}, 128'(bus.pmem_address), 128'(a));
    endtask

    // miss on a, stay lat cycles in ALLOCATE, answer on the last one, then expect the hit
    task automatic fill(input logic [15:0] a, input int lat, input string nm);
        drive(1'b1, a);
        expect_resp({nm, "_miss"}, 1'b0, 128'd0);
        for (int i = 0; i < lat; i++) begin
            tick();
            expect_pmem({nm, "_alloc"}, 1'b1, {a[15:4], 4'h0});
            expect_resp({nm, "_alloc"}, 1'b0, 128'd0);
        end
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line_of(a);
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        #1;
        expect_resp({nm, "_done"}, 1'b1, line_of(a));
        expect_pmem({nm, "_done"}, 1'b0, 16'h0000);
    endtask

    logic [15:0] stream [3];

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b1;
        bus.mem_read    = 1'b0;
        bus.mem_address = '0;
        bus.pmem_resp   = 1'b0;
        bus.pmem_rdata  = '0;
        stream[0] = 16'h0040;
        stream[1] = 16'h0044;
        stream[2] = 16'h004E;

        // reset state, even with a request pending
        tick();
        drive(1'b1, 16'h0042);
        expect_resp("rst", 1'b0, 128'd0);
        expect_pmem("rst", 1'b0, 16'h0000);
        tick();
        expect_pmem("rst2", 1'b0, 16'h0000);
        reset = 1'b0;

        // cold miss: way 0 of set 4
        fill(16'h0042, 5, "cold");

        // back-to-back hits inside the same line
        for (int i = 0; i < 3; i++) begin
            tick();
            drive(1'b1, stream[i]);
            expect_resp("stream", 1'b1, line_of(16'h0040));
            expect_pmem("stream", 1'b0, 16'h0000);
        end

        // conflict: 00C0 goes to way 1, hit 0040 makes way 1 the LRU, 0140 evicts 00C0
        tick();
        fill(16'h00C0, 3, "conf_c0");
        tick();
        drive(1'b1, 16'h0040);
        expect_resp("conf_hit40", 1'b1, line_of(16'h0040));
        tick();
        fill(16'h0140, 2, "conf_140");
        tick();
        drive(1'b1, 16'h0040);
        expect_resp("conf_keep40", 1'b1, line_of(16'h0040));
        tick();
        drive(1'b1, 16'h00C0);
        expect_resp("conf_evict_c0", 1'b0, 128'd0);
        tick();
        expect_pmem("conf_refill_c0", 1'b1, 16'h00C0);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line_of(16'h00C0);
        tick();
        bus.pmem_resp  = 1'b0;
        #1;
        expect_resp("conf_c0_back", 1'b1, line_of(16'h00C0));
        // 0040 was most recently used before the refill, so 0140 is the one evicted
        drive(1'b1, 16'h0140);
        expect_resp("conf_evict_140", 1'b0, 128'd0);
        drive(1'b0, 16'h0140);

        // abandoned request: address moves to a cached line during ALLOCATE
        tick();
        drive(1'b1, 16'h1230);
        expect_resp("abdn_miss", 1'b0, 128'd0);
        tick();
        drive(1'b1, 16'h0040);
        expect_resp("abdn_noresp", 1'b0, 128'd0);
        expect_pmem("abdn_alloc", 1'b1, 16'h1230);
        tick();
        drive(1'b0, 16'h0040);
        expect_pmem("abdn_alloc2", 1'b1, 16'h1230);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line_of(16'h1230);
        tick();
        bus.pmem_resp  = 1'b0;
        drive(1'b0, 16'h1230);
        expect_resp("abdn_after", 1'b0, 128'd0);
        expect_pmem("abdn_after", 1'b0, 16'h0000);
        drive(1'b1, 16'h1230);
        expect_resp("abdn_hit", 1'b1, line_of(16'h1230));

        // spurious fill response in IDLE must not disturb anything
        tick();
        drive(1'b0, 16'h0000);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 128'hDEADBEEF_0BADF00D_FEEDFACE_12345678;
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        #1;
        expect_pmem("spur_idle", 1'b0, 16'h0000);
        drive(1'b1, 16'h0040);
        expect_resp("spur_40", 1'b1, line_of(16'h0040));
        tick();
        drive(1'b1, 16'h00C8);
        expect_resp("spur_c0", 1'b1, line_of(16'h00C0));
        tick();
        drive(1'b1, 16'h123C);
        expect_resp("spur_1230", 1'b1, line_of(16'h1230));

        // reset two cycles into ALLOCATE abandons the fill
        tick();
        drive(1'b1, 16'h2000);
        expect_resp("rfill_miss", 1'b0, 128'd0);
        tick();
        expect_pmem("rfill_alloc", 1'b1, 16'h2000);
        tick();
        reset = 1'b1;
        drive(1'b0, 16'h0000);
        tick();
        reset = 1'b0;
        #1;
        expect_pmem("rfill_dropped", 1'b0, 16'h0000);
        expect_resp("rfill_dropped", 1'b0, 128'd0);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line_of(16'h2000);
        tick();
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        #1;
        expect_pmem("rfill_late_resp", 1'b0, 16'h0000);
        drive(1'b1, 16'h2000);
        expect_resp("rfill_remiss", 1'b0, 128'd0);
        tick();
        expect_pmem("rfill_realloc", 1'b1, 16'h2000);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = line_of(16'h2000);
        tick();
        bus.pmem_resp  = 1'b0;
        #1;
        expect_resp("rfill_hit", 1'b1, line_of(16'h2000));
        // lines cached before the reset are gone
        drive(1'b1, 16'h0040);
        expect_resp("post_rst_40", 1'b0, 128'd0);
        drive(1'b0, 16'h0040);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
